qupls4_mem_hazard_check: RTL and testbench

- Memory-ordering hazard detector used by the memory scheduler to decide whether a candidate load/store can issue.
- Produces three flags:
  - previous unresolved flow-control op in the ROB;
  - previous unfinished memory op in the ROB;
  - address overlap with an older LSQ entry.
- Inputs are flattened per-entry ROB/LSQ fields. Outputs are registered.

---
 rtl/qupls4_mem_hazard_check.sv | 108 ++++++++++
 tb/tb_qupls4_mem_hazard_check.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/qupls4_mem_hazard_check.sv
// qupls4_mem_hazard_check: memory-ordering hazard flags for the scheduler.
// Flags are computed from flattened ROB/LSQ state and registered once.
module qupls4_mem_hazard_check #(
    parameter int ROB_ENTRIES = 16,
    parameter int LSQ_ENTRIES = 8,
    parameter int SNW = 8,
    parameter int PAW = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic [$clog2(ROB_ENTRIES)-1:0] id,
    input  logic seq_consistency,
    input  logic [ROB_ENTRIES-1:0] rob_v,
    input  logic [ROB_ENTRIES*SNW-1:0] rob_sn,
    input  logic [ROB_ENTRIES-1:0] rob_fc,
    input  logic [ROB_ENTRIES-1:0] rob_fc_done,
    input  logic [ROB_ENTRIES-1:0] rob_mem,
    input  logic [ROB_ENTRIES-1:0] rob_agen,
    input  logic [ROB_ENTRIES-1:0] rob_done,
    input  logic [$clog2(LSQ_ENTRIES):0] lsq_id,
    input  logic [LSQ_ENTRIES*2-1:0] lsq_v,
    input  logic [LSQ_ENTRIES*2-1:0] lsq_store,
    input  logic [LSQ_ENTRIES*2-1:0] lsq_agen,
    input  logic [LSQ_ENTRIES*2*PAW-1:0] lsq_padr,
    input  logic [LSQ_ENTRIES*2*SNW-1:0] lsq_sn,
    output logic has_previous_fc,
    output logic has_previous_memop,
    output logic has_overlap
);

    localparam int SLOTS = LSQ_ENTRIES * 2;

    // Modular age compare: x is older than y when (x - y) is "negative".
    function automatic logic older(
        input logic [SNW-1:0] x,
        input logic [SNW-1:0] y
    );
        logic [SNW-1:0] d;
        d = x - y;
        return d[SNW-1];
    endfunction

    int             cand;
    logic [SNW-1:0] cand_sn;
    logic           fc_hit;
    logic           mem_hit;

    always_comb begin
        cand    = int'(id);
        cand_sn = rob_sn[cand*SNW +: SNW];
        fc_hit  = 1'b0;
        mem_hit = 1'b0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            if (rob_v[i] && older(rob_sn[i*SNW +: SNW], cand_sn)) begin
                if (rob_fc[i] && !rob_fc_done[i])
                    fc_hit = 1'b1;
                if (rob_mem[i] &&
                    (seq_consistency ? !rob_done[i] : !rob_agen[i]))
                    mem_hit = 1'b1;
            end
        end
        if (!rob_v[cand]) begin
            fc_hit  = 1'b0;
            mem_hit = 1'b0;
        end
    end

    logic           c_ok;
    int             c;
    logic [PAW-1:0] c_padr;
    logic [SNW-1:0] c_sn;
    logic [PAW-1:0] diff;
    logic           ovl_hit;

    always_comb begin
        c_ok    = int'(lsq_id) < SLOTS;
        c       = c_ok ? int'(lsq_id) : 0;
        c_padr  = lsq_padr[c*PAW +: PAW];
        c_sn    = lsq_sn[c*SNW +: SNW];
        diff    = '0;
        ovl_hit = 1'b0;
        for (int j = 0; j < SLOTS; j++) begin
            if (j != c && lsq_v[j] &&
                older(lsq_sn[j*SNW +: SNW], c_sn) &&
                (lsq_store[j] || lsq_store[c])) begin
                diff = lsq_padr[j*PAW +: PAW] ^ c_padr;
                // Unknown address on either side is treated as a hit.
                if (!lsq_agen[j] || !lsq_agen[c] || (diff >> 4) == '0)
                    ovl_hit = 1'b1;
            end
        end
        if (!c_ok || !lsq_v[c])
            ovl_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            has_previous_fc    <= 1'b0;
            has_previous_memop <= 1'b0;
            has_overlap        <= 1'b0;
        end else begin
            has_previous_fc    <= fc_hit;
            has_previous_memop <= mem_hit;
            has_overlap        <= ovl_hit;
        end
    end

endmodule

// File: tb/tb_qupls4_mem_hazard_check.sv
// tb_qupls4_mem_hazard_check: directed and random checks of the hazard flags
// against an array-based reference model.
module tb_qupls4_mem_hazard_check;

    localparam int RE  = 16;
    localparam int LE  = 8;
    localparam int SL  = LE * 2;
    localparam int SNW = 8;
    localparam int PAW = 32;
    localparam int MOD = 1 << SNW;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] id;
    logic seq_consistency;
    logic [RE-1:0] rob_v, rob_fc, rob_fc_done, rob_mem, rob_agen, rob_done;
    logic [RE*SNW-1:0] rob_sn;
    logic [3:0] lsq_id;
    logic [SL-1:0] lsq_v, lsq_store, lsq_agen;
    logic [SL*PAW-1:0] lsq_padr;
    logic [SL*SNW-1:0] lsq_sn;
    logic has_previous_fc, has_previous_memop, has_overlap;

    // model state
    bit r_v[RE], r_fc[RE], r_fcd[RE], r_mem[RE], r_ag[RE], r_dn[RE];
    int r_sn[RE];
    bit l_v[SL], l_st[SL], l_ag[SL];
    int l_sn[SL];
    longint l_pa[SL];

    int checks = 0;
    int errors = 0;

    qupls4_mem_hazard_check dut (
        .clk(clk), .rst(rst), .id(id),
        .seq_consistency(seq_consistency),
        .rob_v(rob_v), .rob_sn(rob_sn), .rob_fc(rob_fc),
        .rob_fc_done(rob_fc_done), .rob_mem(rob_mem),
        .rob_agen(rob_agen), .rob_done(rob_done),
        .lsq_id(lsq_id), .lsq_v(lsq_v), .lsq_store(lsq_store),
        .lsq_agen(lsq_agen), .lsq_padr(lsq_padr), .lsq_sn(lsq_sn),
        .has_previous_fc(has_previous_fc),
        .has_previous_memop(has_previous_memop),
        .has_overlap(has_overlap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic bit m_older(input int a, input int b);
        return (((a - b) % MOD + MOD) % MOD) >= MOD / 2;
    endfunction

    function automatic bit m_fc();
        int k = int'(id);
        if (!r_v[k]) return 0;
        for (int i = 0; i < RE; i++)
            if (r_v[i] && r_fc[i] && !r_fcd[i] && m_older(r_sn[i], r_sn[k]))
                return 1;
        return 0;
    endfunction

    function automatic bit m_mem();
        int k = int'(id);
        bit pend;
        if (!r_v[k]) return 0;
        for (int i = 0; i < RE; i++) begin
            pend = seq_consistency ? !r_dn[i] : !r_ag[i];
            if (r_v[i] && r_mem[i] && pend && m_older(r_sn[i], r_sn[k]))
                return 1;
        end
        return 0;
    endfunction

    function automatic bit m_ovl();
        int c = int'(lsq_id);
        if (c / 2 >= LE) return 0;
        if (!l_v[c]) return 0;
        for (int j = 0; j < SL; j++) begin
            if (j == c || !l_v[j] || !m_older(l_sn[j], l_sn[c])) continue;
            if (!l_st[j] && !l_st[c]) continue;
            if (!l_ag[j] || !l_ag[c]) return 1;
            if (l_pa[j] / 16 == l_pa[c] / 16) return 1;
        end
        return 0;
    endfunction

    task automatic pack();
        for (int i = 0; i < RE; i++) begin
            rob_v[i] = r_v[i];
            rob_fc[i] = r_fc[i];
            rob_fc_done[i] = r_fcd[i];
            rob_mem[i] = r_mem[i];
            rob_agen[i] = r_ag[i];
            rob_done[i] = r_dn[i];
            rob_sn[i*SNW +: SNW] = SNW'(r_sn[i]);
        end
        for (int j = 0; j < SL; j++) begin
            lsq_v[j] = l_v[j];
            lsq_store[j] = l_st[j];
            lsq_agen[j] = l_ag[j];
            lsq_sn[j*SNW +: SNW] = SNW'(l_sn[j]);
            lsq_padr[j*PAW +: PAW] = PAW'(l_pa[j]);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < RE; i++) begin
            r_v[i] = 0; r_fc[i] = 0; r_fcd[i] = 0;
            r_mem[i] = 0; r_ag[i] = 0; r_dn[i] = 0;
            r_sn[i] = 0;
        end
        for (int j = 0; j < SL; j++) begin
            l_v[j] = 0; l_st[j] = 0; l_ag[j] = 0;
            l_sn[j] = 0; l_pa[j] = 0;
        end
    endtask

    task automatic step(input string tag);
        bit efc, emem, eovl;
        pack();
        efc  = rst ? 0 : m_fc();
        emem = rst ? 0 : m_mem();
        eovl = rst ? 0 : m_ovl();
        @(posedge clk);
        #1;
        check({tag, "_fc"}, has_previous_fc, efc);
        check({tag, "_mem"}, has_previous_memop, emem);
        check({tag, "_ovl"}, has_overlap, eovl);
    endtask

    task automatic step_exp(input string tag, input bit f, input bit m,
                            input bit o);
        pack();
        @(posedge clk);
        #1;
        check({tag, "_fc"}, has_previous_fc, f);
        check({tag, "_mem"}, has_previous_memop, m);
        check({tag, "_ovl"}, has_overlap, o);
    endtask

    initial begin
        rst = 1'b1;
        id = 4'd7;
        lsq_id = 4'd3;
        seq_consistency = 1'b1;
        clear();
        // hazards on every flag while reset is held
        r_v[7] = 1; r_sn[7] = 9;
        r_v[3] = 1; r_fc[3] = 1; r_sn[3] = 5;
        r_v[2] = 1; r_mem[2] = 1; r_ag[2] = 1; r_sn[2] = 4;
        l_v[0] = 1; l_st[0] = 1; l_ag[0] = 1; l_sn[0] = 3;
        l_pa[0] = 64'h1008;
        l_v[3] = 1; l_ag[3] = 1; l_sn[3] = 6; l_pa[3] = 64'h100C;
        step_exp("rst0", 0, 0, 0);
        step_exp("rst1", 0, 0, 0);
        rst = 1'b0;
        step_exp("post_rst", 1, 1, 1);

        // flow control
        r_fcd[3] = 1;
        step_exp("fc_done", 0, 1, 1);
        r_fcd[3] = 0; r_sn[3] = 12;
        step_exp("fc_younger", 0, 1, 1);
        r_sn[3] = 5;

        // memop
        seq_consistency = 1'b0;
        step_exp("mem_sc0_agen", 1, 0, 1);
        r_ag[2] = 0;
        step_exp("mem_sc0_noagen", 1, 1, 1);
        r_ag[2] = 1;
        seq_consistency = 1'b1;

        // overlap
        l_pa[3] = 64'h1010;
        step_exp("ovl_granule", 1, 1, 0);
        l_pa[3] = 64'h100C; l_st[0] = 0;
        step_exp("ovl_ld_ld", 1, 1, 0);
        l_st[0] = 1; l_ag[0] = 0; l_pa[0] = 64'h2000;
        step_exp("ovl_noagen", 1, 1, 1);
        l_ag[0] = 1; l_pa[0] = 64'h1008;

        // sequence wrap
        r_sn[7] = 8'h02; r_sn[3] = 8'hFE; r_sn[2] = 8'hFD;
        l_sn[3] = 8'h02; l_sn[0] = 8'hFE;
        step_exp("wrap_older", 1, 1, 1);
        r_sn[3] = 8'h03; r_sn[2] = 8'h03; l_sn[0] = 8'h03;
        step_exp("wrap_younger", 0, 0, 0);
        r_sn[3] = 8'hFE; r_sn[2] = 8'hFD; l_sn[0] = 8'hFE;

        // invalid candidates
        r_v[7] = 0; l_v[3] = 0;
        step_exp("cand_invalid", 0, 0, 0);
        r_v[7] = 1; l_v[3] = 1;
        step_exp("cand_valid", 1, 1, 1);

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            id = 4'($urandom_range(0, RE - 1));
            lsq_id = 4'($urandom_range(0, SL - 1));
            seq_consistency = 1'($urandom_range(0, 1));
            for (int i = 0; i < RE; i++) begin
                r_v[i] = ($urandom_range(0, 3) != 0);
                r_fc[i] = ($urandom_range(0, 5) == 0);
                r_fcd[i] = 1'($urandom_range(0, 1));
                r_mem[i] = ($urandom_range(0, 4) == 0);
                r_ag[i] = 1'($urandom_range(0, 1));
                r_dn[i] = 1'($urandom_range(0, 1));
                r_sn[i] = int'($urandom_range(0, MOD - 1));
            end
            for (int j = 0; j < SL; j++) begin
                l_v[j] = ($urandom_range(0, 2) != 0);
                l_st[j] = ($urandom_range(0, 2) == 0);
                l_ag[j] = ($urandom_range(0, 4) != 0);
                l_sn[j] = int'($urandom_range(0, MOD - 1));
                l_pa[j] = longint'($urandom_range(0, 255)) * 16
                        + longint'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1)
                    l_pa[j] = 64'h4000 + longint'($urandom_range(0, 47));
            end
            step("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
